// File: rtl/bicintp_wr_sched.sv
// Write-side scheduler: buffers interpolated pixels in a show-ahead FIFO and
// issues fixed-length DDR write bursts with linear frame addressing.
module bicintp_wr_sched #(
  parameter int                 DATA_W      = 16,
  parameter int                 FIFO_AW     = 8,
  parameter int                 BURST_LEN   = 64,
  parameter int                 ADDR_W      = 24,
  parameter logic [ADDR_W-1:0]  BASE_ADDR   = '0,
  parameter int                 FRAME_WORDS = 786432
) (
  input  logic                sys_clk,
  input  logic                sys_rstn,
  input  logic                frame_start,
  input  logic                pix_vld,
  input  logic [DATA_W-1:0]   pix_data,
  output logic                ddr_wr_req,
  input  logic                ddr_wr_ack,
  output logic [ADDR_W-1:0]   ddr_wr_addr,
  input  logic                ddr_wr_data_req,
  output logic [DATA_W-1:0]   ddr_wr_data,
  input  logic                ddr_wr_done,
  output logic [FIFO_AW:0]    fifo_level,
  output logic                frame_done,
  output logic                fifo_ovf
);

  localparam int                DEPTH     = 1 << FIFO_AW;
  localparam int                BW        = $clog2(BURST_LEN + 1);
  localparam logic [FIFO_AW:0]  DEPTH_L   = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0]  BURST_L   = (FIFO_AW+1)'(BURST_LEN);
  localparam logic [BW-1:0]     LAST_BEAT = BW'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0] BURST_A   = ADDR_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] FRAME_A   = ADDR_W'(FRAME_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA, S_WAIT} state_t;

  state_t               state_q, state_d;
  logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]     level_q, level_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [ADDR_W-1:0]    off_q, off_d;
  logic [BW-1:0]        beat_q, beat_d;
  logic                 pend_q, pend_d;
  logic                 ovf_q, ovf_d;
  logic                 fdone_q, fdone_d;
  logic                 push_req, push, pop;
  logic [DATA_W-1:0]    mem_q [DEPTH];

  always_ff @(posedge sys_clk) begin
    if (sys_rstn) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      addr_q   <= BASE_ADDR;
      off_q    <= '0;
      beat_q   <= '0;
      pend_q   <= 1'b0;
      ovf_q    <= 1'b0;
      fdone_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      addr_q   <= addr_d;
      off_q    <= off_d;
      beat_q   <= beat_d;
      pend_q   <= pend_d;
      ovf_q    <= ovf_d;
      fdone_q  <= fdone_d;
    end
  end

  // Storage carries no reset; emptiness is tracked by level_q alone.
  always_ff @(posedge sys_clk) begin
    if (push) mem_q[wr_ptr_q] <= pix_data;
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    addr_d   = addr_q;
    off_d    = off_q;
    beat_d   = beat_q;
    pend_d   = pend_q | frame_start;
    ovf_d    = ovf_q;
    fdone_d  = 1'b0;

    pop      = (state_q == S_DATA) && ddr_wr_data_req && (level_q != '0);
    push_req = pix_vld && !pend_q;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    push     = push_req && ((level_q < DEPTH_L) || pop);

    if (push_req && !push) ovf_d = 1'b1;
    if (push) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + (FIFO_AW+1)'(1);
      2'b01:   level_d = level_q - (FIFO_AW+1)'(1);
      default: level_d = level_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          level_d  = '0;
          addr_d   = BASE_ADDR;
          off_d    = '0;
          ovf_d    = 1'b0;
          pend_d   = frame_start;
        end else if (level_q >= BURST_L) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (ddr_wr_ack) begin
          state_d = S_DATA;
          beat_d  = '0;
        end
      end
      S_DATA: begin
        if (pop) begin
          beat_d = beat_q + BW'(1);
          if (beat_q == LAST_BEAT) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ddr_wr_done) begin
          state_d = S_IDLE;
          // Wrap to the frame base once the last burst of the frame commits.
          if (off_q + BURST_A == FRAME_A) begin
            addr_d  = BASE_ADDR;
            off_d   = '0;
            fdone_d = 1'b1;
          end else begin
            addr_d = addr_q + BURST_A;
            off_d  = off_q + BURST_A;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ddr_wr_req  = (state_q == S_REQ);
  assign ddr_wr_addr = addr_q;
  assign ddr_wr_data = (level_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign fifo_level  = level_q;
  assign frame_done  = fdone_q;
  assign fifo_ovf    = ovf_q;

endmodule

// File: tb/tb_bicintp_wr_sched.sv
// Directed bench for bicintp_wr_sched: vector table for FIFO/IDLE behaviour,
// hand sequences for bursts, frame wrap, overflow, flush and reset.
module tb_bicintp_wr_sched;

  logic        clk = 1'b0;
  logic        rst, frame_start, pix_vld, ack, dreq, done;
  logic [15:0] pix_data;
  logic        ddr_wr_req, frame_done, fifo_ovf;
  logic [23:0] ddr_wr_addr;
  logic [15:0] ddr_wr_data;
  logic [8:0]  fifo_level;

  int nvec = 0;
  int nerr = 0;

  bicintp_wr_sched #(
    .DATA_W(16), .FIFO_AW(8), .BURST_LEN(64), .ADDR_W(24),
    .BASE_ADDR(24'd0), .FRAME_WORDS(256)
  ) dut (
    .sys_clk(clk), .sys_rstn(rst), .frame_start(frame_start),
    .pix_vld(pix_vld), .pix_data(pix_data),
    .ddr_wr_req(ddr_wr_req), .ddr_wr_ack(ack), .ddr_wr_addr(ddr_wr_addr),
    .ddr_wr_data_req(dreq), .ddr_wr_data(ddr_wr_data), .ddr_wr_done(done),
    .fifo_level(fifo_level), .frame_done(frame_done), .fifo_ovf(fifo_ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        vld;
    logic [15:0] data;
    logic        dreq;
    logic [8:0]  e_level;
    logic [15:0] e_data;
    logic        e_req;
  } vec_t;

  vec_t tbl [6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; frame_start = 1'b0; pix_vld = 1'b0; pix_data = '0;
    ack = 1'b0; dreq = 1'b0; done = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic push_n(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      pix_vld  = 1'b1;
      pix_data = base + 16'(i);
      step();
    end
    pix_vld = 1'b0;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!ddr_wr_req && n < 500) begin
      step();
      n++;
    end
    chk(name, 32'(ddr_wr_req), 32'd1);
  endtask

  task automatic ack_once();
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b1, 16'hA5A5, 1'b0, 9'd1, 16'hA5A5, 1'b0};
    tbl[1] = '{1'b1, 16'h1234, 1'b1, 9'd2, 16'hA5A5, 1'b0};
    tbl[2] = '{1'b0, 16'h0000, 1'b1, 9'd2, 16'hA5A5, 1'b0};
    tbl[3] = '{1'b1, 16'hBEEF, 1'b0, 9'd3, 16'hA5A5, 1'b0};
    tbl[4] = '{1'b0, 16'h0000, 1'b1, 9'd3, 16'hA5A5, 1'b0};
    tbl[5] = '{1'b0, 16'h0000, 1'b0, 9'd3, 16'hA5A5, 1'b0};

    // Reset state, checked while reset is still held
    rst = 1'b1; frame_start = 1'b0; pix_vld = 1'b0; pix_data = '0;
    ack = 1'b0; dreq = 1'b0; done = 1'b0;
    step();
    chk("rst_req", 32'(ddr_wr_req), 32'd0);
    chk("rst_addr", 32'(ddr_wr_addr), 32'd0);
    chk("rst_data", 32'(ddr_wr_data), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_fdone", 32'(frame_done), 32'd0);
    chk("rst_ovf", 32'(fifo_ovf), 32'd0);
    rst = 1'b0;

    // Vector table: pushes in IDLE, data_req ignored outside DATA
    for (int i = 0; i < 6; i++) begin
      pix_vld  = tbl[i].vld;
      pix_data = tbl[i].data;
      dreq     = tbl[i].dreq;
      step();
      chk($sformatf("tbl%0d_level", i), 32'(fifo_level), 32'(tbl[i].e_level));
      chk($sformatf("tbl%0d_data", i), 32'(ddr_wr_data), 32'(tbl[i].e_data));
      chk($sformatf("tbl%0d_req", i), 32'(ddr_wr_req), 32'(tbl[i].e_req));
    end
    pix_vld = 1'b0; dreq = 1'b0;

    // Flush in IDLE; pixel offered while pending is dropped without overflow
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    pix_vld = 1'b1; pix_data = 16'h7777;
    step();
    pix_vld = 1'b0;
    chk("idle_flush_level", 32'(fifo_level), 32'd0);
    chk("idle_flush_data", 32'(ddr_wr_data), 32'd0);
    chk("idle_flush_ovf", 32'(fifo_ovf), 32'd0);

    // Single burst with request latency and in-order data
    do_reset();
    push_n(64, 16'h0000);
    chk("b1_level64", 32'(fifo_level), 32'd64);
    chk("b1_req_n1", 32'(ddr_wr_req), 32'd0);
    step();
    chk("b1_req_n2", 32'(ddr_wr_req), 32'd1);
    chk("b1_addr", 32'(ddr_wr_addr), 32'd0);
    step();
    chk("b1_req_hold", 32'(ddr_wr_req), 32'd1);
    ack_once();
    chk("b1_req_drop", 32'(ddr_wr_req), 32'd0);
    for (int j = 0; j < 64; j++) begin
      chk($sformatf("b1_data%0d", j), 32'(ddr_wr_data), 32'(j));
      dreq = 1'b1;
      step();
    end
    dreq = 1'b0;
    chk("b1_level_end", 32'(fifo_level), 32'd0);
    pix_vld = 1'b1; pix_data = 16'h0100; dreq = 1'b1;
    step();
    pix_vld = 1'b0;
    step();
    dreq = 1'b0;
    chk("wait_nopop_level", 32'(fifo_level), 32'd1);
    chk("wait_nopop_data", 32'(ddr_wr_data), 32'h0100);
    done = 1'b1;
    step();
    done = 1'b0;
    chk("b1_done_addr", 32'(ddr_wr_addr), 32'd64);
    chk("b1_done_fdone", 32'(frame_done), 32'd0);

    // Full frame with a responsive DDR: four bursts, then wrap to base
    do_reset();
    fork
      begin
        for (int i = 0; i < 256; i++) begin
          pix_vld = 1'b1; pix_data = 16'(i);
          step();
        end
        pix_vld = 1'b0;
      end
      begin
        for (int b = 0; b < 4; b++) begin
          wait_req($sformatf("fr_req%0d", b));
          chk($sformatf("fr_addr%0d", b), 32'(ddr_wr_addr), 32'(b * 64));
          ack_once();
          for (int j = 0; j < 64; j++) begin
            chk($sformatf("fr_data%0d_%0d", b, j), 32'(ddr_wr_data), 32'(b * 64 + j));
            dreq = 1'b1;
            step();
          end
          dreq = 1'b0;
          done = 1'b1;
          step();
          done = 1'b0;
          chk($sformatf("fr_fdone%0d", b), 32'(frame_done), (b == 3) ? 32'd1 : 32'd0);
          chk($sformatf("fr_naddr%0d", b), 32'(ddr_wr_addr), (b == 3) ? 32'd0 : 32'((b + 1) * 64));
        end
        step();
        chk("fr_fdone_pulse", 32'(frame_done), 32'd0);
      end
    join
    chk("fr_level", 32'(fifo_level), 32'd0);
    chk("fr_ovf", 32'(fifo_ovf), 32'd0);

    // Overflow under a stalled DDR; sticky until flushed
    do_reset();
    push_n(256, 16'h0000);
    chk("ov_level_full", 32'(fifo_level), 32'd256);
    chk("ov_ovf_clear", 32'(fifo_ovf), 32'd0);
    push_n(4, 16'h1000);
    chk("ov_level_sat", 32'(fifo_level), 32'd256);
    chk("ov_ovf_set", 32'(fifo_ovf), 32'd1);
    wait_req("ov_req");
    ack_once();
    for (int j = 0; j < 64; j++) begin
      chk($sformatf("ov_data%0d", j), 32'(ddr_wr_data), 32'(j));
      dreq = 1'b1;
      step();
    end
    dreq = 1'b0;
    chk("ov_level192", 32'(fifo_level), 32'd192);
    chk("ov_head", 32'(ddr_wr_data), 32'h40);
    chk("ov_sticky", 32'(fifo_ovf), 32'd1);
    done = 1'b1; frame_start = 1'b1;
    step();
    done = 1'b0; frame_start = 1'b0;
    chk("ov_done_addr", 32'(ddr_wr_addr), 32'd64);
    chk("ov_still_set", 32'(fifo_ovf), 32'd1);
    step();
    chk("ov_flush_level", 32'(fifo_level), 32'd0);
    chk("ov_flush_ovf", 32'(fifo_ovf), 32'd0);
    chk("ov_flush_addr", 32'(ddr_wr_addr), 32'd0);
    chk("ov_flush_req", 32'(ddr_wr_req), 32'd0);

    // frame_start mid-burst: burst finishes, then flush
    do_reset();
    push_n(64, 16'h0200);
    wait_req("fs_req");
    ack_once();
    for (int j = 0; j < 64; j++) begin
      frame_start = (j == 10);
      pix_vld     = (j >= 12 && j < 17);
      pix_data    = 16'hDEAD;
      chk($sformatf("fs_data%0d", j), 32'(ddr_wr_data), 32'(16'h0200 + 16'(j)));
      dreq = 1'b1;
      step();
    end
    frame_start = 1'b0; pix_vld = 1'b0; dreq = 1'b0;
    chk("fs_level_end", 32'(fifo_level), 32'd0);
    chk("fs_ovf", 32'(fifo_ovf), 32'd0);
    chk("fs_req", 32'(ddr_wr_req), 32'd0);
    done = 1'b1;
    step();
    done = 1'b0;
    chk("fs_done_addr", 32'(ddr_wr_addr), 32'd64);
    step();
    chk("fs_flush_addr", 32'(ddr_wr_addr), 32'd0);
    chk("fs_flush_level", 32'(fifo_level), 32'd0);
    push_n(1, 16'h0055);
    chk("fs_resume_level", 32'(fifo_level), 32'd1);
    chk("fs_resume_data", 32'(ddr_wr_data), 32'h0055);

    // Full FIFO with simultaneous push and pop
    do_reset();
    push_n(256, 16'h0300);
    wait_req("fp_req");
    ack_once();
    pix_vld = 1'b1; pix_data = 16'hF00D; dreq = 1'b1;
    step();
    dreq = 1'b0;
    chk("fp_level", 32'(fifo_level), 32'd256);
    chk("fp_ovf", 32'(fifo_ovf), 32'd0);
    chk("fp_head", 32'(ddr_wr_data), 32'h0301);
    pix_data = 16'hBEEF;
    step();
    pix_vld = 1'b0;
    chk("fp_drop_level", 32'(fifo_level), 32'd256);
    chk("fp_drop_ovf", 32'(fifo_ovf), 32'd1);

    // Reset in the middle of a burst
    do_reset();
    push_n(64, 16'h0400);
    wait_req("rd_req");
    ack_once();
    dreq = 1'b1;
    for (int j = 0; j < 5; j++) step();
    chk("rd_level59", 32'(fifo_level), 32'd59);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rd_req", 32'(ddr_wr_req), 32'd0);
    chk("rd_level", 32'(fifo_level), 32'd0);
    chk("rd_addr", 32'(ddr_wr_addr), 32'd0);
    chk("rd_data", 32'(ddr_wr_data), 32'd0);
    step();
    step();
    dreq = 1'b0;
    chk("rd_idle_level", 32'(fifo_level), 32'd0);
    chk("rd_idle_req", 32'(ddr_wr_req), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/bicintp_wr_sched.md
Name: bicintp_wr_sched

Overview:
- Write-side scheduler between the interpolation datapath output (cmos_bicintp_data / cmos_bicintp_data_vld) and the DDR user write port.
- Buffers interpolated pixels in an internal FIFO and issues fixed-length DDR write bursts whenever a full burst is available.
- Generates linear frame addresses, and signals frame completion and overflow to the system.

Parameters:
- DATA_W, 16, pixel word width.
- FIFO_AW, 8, FIFO address width; depth = 2^FIFO_AW = 256 words.
- BURST_LEN, 64, words per DDR write burst. Must satisfy 1 ≤ BURST_LEN ≤ depth.
- ADDR_W, 24, DDR word-address width.
- BASE_ADDR, 0, frame start address.
- FRAME_WORDS, 786432, words per output frame. Must be a multiple of BURST_LEN.

Ports:
- sys_clk, in, 1, system/DDR user clock. All logic is on this clock.
- sys_rstn, in, 1, reset, synchronous, active-high.
- frame_start, in, 1, one-cycle pulse marking the start of a new output frame.
- pix_vld, in, 1, interpolated pixel valid.
- pix_data, in, DATA_W, interpolated pixel.
- ddr_wr_req, out, 1, burst request.
- ddr_wr_ack, in, 1, one-cycle acceptance of the request.
- ddr_wr_addr, out, ADDR_W, burst start word address.
- ddr_wr_data_req, in, 1, DDR pulls one word per high cycle.
- ddr_wr_data, out, DATA_W, write word.
- ddr_wr_done, in, 1, one-cycle pulse when the burst is committed.
- fifo_level, out, FIFO_AW+1, current word count.
- frame_done, out, 1, one-cycle pulse after the last burst of a frame.
- fifo_ovf, out, 1, sticky overflow flag.

Behaviour:
- Reset (sys_rstn=1 at a sys_clk edge):
  - state=IDLE, FIFO empty.
  - ddr_wr_req=0, ddr_wr_addr=BASE_ADDR, ddr_wr_data=0, fifo_level=0, frame_done=0, fifo_ovf=0.
  - Reset mid-burst abandons the burst with no further handshakes.
- FIFO:
  - Show-ahead: ddr_wr_data always presents the head word, or 0 when empty.
  - Push: on pix_vld, accepted if level < depth OR a pop occurs in the same cycle.
  - Otherwise the word is dropped and fifo_ovf is set.
  - Pointers wrap modulo depth. fifo_level is updated registered, +push −pop.
- State IDLE:
  - If frame_pend=1: flush FIFO, set ddr_wr_addr=BASE_ADDR, clear fifo_ovf, clear frame_pend.
  - Else if level ≥ BURST_LEN: go to REQ.
- State REQ:
  - ddr_wr_req=1. ddr_wr_addr is held stable until ddr_wr_ack.
  - On ddr_wr_ack: ddr_wr_req=0 the next cycle, go to DATA, beat counter=0.
- State DATA:
  - Each cycle with ddr_wr_data_req=1 pops one word and increments the beat counter.
  - After the pop with beat counter = BURST_LEN−1, go to WAIT.
  - ddr_wr_data_req is ignored in IDLE/REQ/WAIT (no pop).
  - The FIFO cannot underflow, because entry to REQ guarantees BURST_LEN words.
- State WAIT:
  - On ddr_wr_done: ddr_wr_addr += BURST_LEN.
  - If the new offset equals FRAME_WORDS: ddr_wr_addr=BASE_ADDR and pulse frame_done for 1 cycle.
  - Then go to IDLE.
- frame_start handling:
  - frame_start sets frame_pend.
  - Sampled in IDLE, the flush occurs the following cycle.
  - During REQ/DATA/WAIT, the current burst completes normally and the flush happens on return to IDLE.
  - While frame_pend=1, incoming pixels are discarded (not counted as overflow).
  - A frame_start coincident with the frame_done cycle still flushes.
- Latency:
  - The pix_vld that makes level reach BURST_LEN in cycle N makes the level visible in N+1, IDLE sees it in N+1, and ddr_wr_req=1 in N+2.
- No partial bursts are ever issued.

Test Plan:
- Reset, then 64 pix_vld beats 0x0000..0x003F → ddr_wr_req rises 2 cycles after the 64th push with addr 0. Ack, then 64 data_req → data 0x0000..0x003F in order. done → addr 64, fifo_level 0.
- FRAME_WORDS=256: stream 256 pixels with prompt DDR → bursts at addrs 0/64/128/192. frame_done pulses once after the 4th done. ddr_wr_addr returns to 0.
- DDR stalls (no ack), push 260 pixels → fifo_level saturates at 256, fifo_ovf=1, 4 words dropped. After ack + 64 pops, level=192. fifo_ovf stays 1 until frame_start.
- frame_start asserted in DATA at beat 10 → remaining 54 beats are delivered and the done handshake completes. Then FIFO is flushed, addr=BASE_ADDR, fifo_ovf=0. Pixels sent during pend are dropped.
- Level 256 (full), with data_req pop and pix_vld in the same cycle → push accepted, level stays 256, fifo_ovf stays 0.
- data_req pulses in IDLE and WAIT → no pop, level unchanged. Reset asserted in DATA → next cycle ddr_wr_req=0, level=0, addr=0.
